// File: rtl/cut_vector_sequencer.sv
// Stores PODEM vectors for a full-adder CUT, applies them in order and counts response mismatches.
// Optional MISR signature of the captured responses is enabled with the CUT_MISR_EN macro.
module cut_vector_sequencer #(
    parameter int DEPTH      = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [4:0]                     load_vec,
    input  logic                           start,
    input  logic                           clear,
    output logic                           busy,
    output logic                           done,
    output logic                           cut_a,
    output logic                           cut_b,
    output logic                           cut_cin,
    input  logic                           cut_sum,
    input  logic                           cut_cout,
    output logic [$clog2(DEPTH+1)-1:0]     vec_count,
    output logic [$clog2(DEPTH+1)-1:0]     fail_count,
    output logic                           first_fail_vld,
`ifdef CUT_MISR_EN
    output logic [$clog2(DEPTH)-1:0]       first_fail_idx,
    output logic [7:0]                     signature
`else
    output logic [$clog2(DEPTH)-1:0]       first_fail_idx
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     mem [DEPTH];
    logic [CW-1:0]  vec_count_q, vec_count_d;
    logic [CW-1:0]  fail_q, fail_d;
    logic           ffv_q, ffv_d;
    logic [IW-1:0]  ffi_q, ffi_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [2:0]     cut_q, cut_d;
    logic [1:0]     exp_q, exp_d;
`ifdef CUT_MISR_EN
    logic [7:0]     sig_q, sig_d;
`endif
    logic           wr_en;
    logic [IW-1:0]  rd_addr;
    logic [4:0]     rd_vec;
    logic           mismatch;

    // Next vector to drive: entry 0 on start, idx+1 when leaving CAPTURE.
    assign rd_addr  = (state_q == S_CAPTURE) ? idx_q + IW'(1) : '0;
    assign rd_vec   = mem[rd_addr];
    assign mismatch = ({cut_cout, cut_sum} != exp_q);

    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        fail_d      = fail_q;
        ffv_d       = ffv_q;
        ffi_d       = ffi_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cut_d       = cut_q;
        exp_d       = exp_q;
`ifdef CUT_MISR_EN
        sig_d       = sig_q;
`endif
        load_ready  = (state_q == S_IDLE) && (vec_count_q < CW'(DEPTH));
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (clear) begin
                    state_d     = S_IDLE;
                    vec_count_d = '0;
                    fail_d      = '0;
                    ffv_d       = 1'b0;
                    ffi_d       = '0;
                    idx_d       = '0;
`ifdef CUT_MISR_EN
                    sig_d       = 8'h00;
`endif
                end else if (load_valid && load_ready) begin
                    wr_en       = 1'b1;
                    vec_count_d = vec_count_q + CW'(1);
                end else if (start) begin
                    fail_d = '0;
                    ffv_d  = 1'b0;
                    ffi_d  = '0;
                    idx_d  = '0;
`ifdef CUT_MISR_EN
                    sig_d  = 8'h00;
`endif
                    if (vec_count_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cut_d   = rd_vec[2:0];
                        exp_d   = rd_vec[4:3];
                        cnt_d   = SW'(SETTLE_CYC);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (mismatch) begin
                    fail_d = fail_q + CW'(1);
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end
`ifdef CUT_MISR_EN
                sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00) ^ {6'b0, cut_cout, cut_sum};
`endif
                if (CW'(idx_q) == vec_count_q - CW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    cut_d   = rd_vec[2:0];
                    exp_d   = rd_vec[4:3];
                    cnt_d   = SW'(SETTLE_CYC);
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_count_q <= '0;
            fail_q      <= '0;
            ffv_q       <= 1'b0;
            ffi_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cut_q       <= '0;
            exp_q       <= '0;
`ifdef CUT_MISR_EN
            sig_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            vec_count_q <= vec_count_d;
            fail_q      <= fail_d;
            ffv_q       <= ffv_d;
            ffi_q       <= ffi_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cut_q       <= cut_d;
            exp_q       <= exp_d;
`ifdef CUT_MISR_EN
            sig_q       <= sig_d;
`endif
        end
    end

    // Vector store has no reset; vec_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[vec_count_q[IW-1:0]] <= load_vec;
        end
    end

    assign busy           = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done           = (state_q == S_DONE);
    assign cut_a          = cut_q[0];
    assign cut_b          = cut_q[1];
    assign cut_cin        = cut_q[2];
    assign vec_count      = vec_count_q;
    assign fail_count     = fail_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffi_q;
`ifdef CUT_MISR_EN
    assign signature      = sig_q;
`endif

endmodule

// File: tb/tb_cut_vector_sequencer.sv
// Bench for cut_vector_sequencer: golden full-adder CUT, cycle-level model checked every cycle,
// plus directed scenarios with literal expectations. Signature checks apply when CUT_MISR_EN is defined.
module tb_cut_vector_sequencer;
    localparam int DEPTH = 16;
    localparam int S     = 1;
    localparam int P     = S + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] load_vec = 5'd0;
    logic       load_ready, busy, done, cut_a, cut_b, cut_cin, cut_sum, cut_cout, first_fail_vld;
    logic [4:0] vec_count, fail_count;
    logic [3:0] first_fail_idx;
`ifdef CUT_MISR_EN
    logic [7:0] signature;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Golden full adder as the circuit under test.
    assign {cut_cout, cut_sum} = 2'(cut_a) + 2'(cut_b) + 2'(cut_cin);

    cut_vector_sequencer #(.DEPTH(DEPTH), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_vec(load_vec), .start(start), .clear(clear), .busy(busy), .done(done),
        .cut_a(cut_a), .cut_b(cut_b), .cut_cin(cut_cin), .cut_sum(cut_sum), .cut_cout(cut_cout),
        .vec_count(vec_count), .fail_count(fail_count), .first_fail_vld(first_fail_vld),
`ifdef CUT_MISR_EN
        .first_fail_idx(first_fail_idx), .signature(signature)
`else
        .first_fail_idx(first_fail_idx)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_store[DEPTH];
    int m_cnt  = 0;
    int m_mode = 0;   // 0: idle (no results), 1: a run was started (running or done)
    int m_el   = 0;   // edges since the start edge
    int m_cut  = 0;

    function automatic int resp(input int v);
        return (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
    endfunction

    function automatic bit mism(input int v);
        return ((v >> 3) & 3) != resp(v);
    endfunction

    initial begin
        int  k, ef, fv, fi, sg, vi;
        bit  running;
        @(posedge clk);
        forever begin
            @(negedge clk);
            running = (m_mode == 1) && (m_el < m_cnt * P);
            k = 0;
            if (m_mode == 1) k = (m_el / P < m_cnt) ? m_el / P : m_cnt;
            ef = 0; fv = 0; fi = 0; sg = 0;
            for (int i = 0; i < k; i++) begin
                if (mism(m_store[i])) begin
                    if (fv == 0) begin fv = 1; fi = i; end
                    ef++;
                end
                sg = ((sg << 1) & 8'hFF) ^ (((sg & 8'h80) != 0) ? 8'h1D : 8'h00) ^ resp(m_store[i]);
            end
            chk("load_ready", load_ready, (m_mode == 0) && (m_cnt < DEPTH));
            chk("busy", busy, running);
            chk("done", done, (m_mode == 1) && !running);
            chk("vec_count", vec_count, m_cnt);
            chk("fail_count", fail_count, ef);
            chk("first_fail_vld", first_fail_vld, fv);
            chk("first_fail_idx", first_fail_idx, fi);
            chk("cut_drive", {cut_cin, cut_b, cut_a}, m_cut);
`ifdef CUT_MISR_EN
            chk("signature", signature, sg);
`endif
            // advance by the edge that will sample the currently held inputs
            if (rst) begin
                m_mode = 0; m_cnt = 0; m_el = 0; m_cut = 0;
            end else if (running) begin
                m_el++;
            end else if (clear) begin
                m_mode = 0; m_cnt = 0;
            end else if (m_mode == 0 && load_valid && m_cnt < DEPTH) begin
                m_store[m_cnt] = load_vec;
                m_cnt++;
            end else if (start) begin
                m_mode = 1; m_el = 0;
            end else if (m_mode == 1) begin
                m_el++;
            end
            if (!rst && m_mode == 1 && m_cnt > 0) begin
                vi = (m_el / P < m_cnt - 1) ? m_el / P : m_cnt - 1;
                m_cut = m_store[vi] & 7;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [4:0] v);
        load_valid = 1'b1;
        load_vec   = v;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Returns cycles from the start edge until done is seen.
    task automatic run(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) chk("run_timeout", done, 1'b1);
    endtask

    function automatic logic [4:0] mkvec(input int i, input bit wrong);
        logic [1:0] r;
        logic       a, b, c;
        a = i[0]; b = i[1]; c = i[2];
        r = 2'(a) + 2'(b) + 2'(c);
        if (wrong) r = r ^ 2'b11;
        return {r, c, b, a};
    endfunction

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_vec_count", vec_count, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fail_count", fail_count, 0);

        // empty run: done right after the start edge, busy never seen
        run(n);
        chk("empty_latency", n, 0);
        chk("empty_busy", busy, 1'b0);
        chk("empty_fail", fail_count, 0);
        do_clear();
        chk("clear_done", done, 1'b0);

        // load handshake beats start in the same cycle
        load_valid = 1'b1; load_vec = mkvec(0, 1'b0); start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        chk("load_wins_busy", busy, 1'b0);
        chk("load_wins_count", vec_count, 1);

        // exhaustive golden run
        for (int i = 1; i < 8; i++) load(mkvec(i, 1'b0));
        run(n);
        chk("golden_latency", n, 16);
        chk("golden_fail", fail_count, 0);
        chk("golden_vld", first_fail_vld, 1'b0);
        run(n);
        chk("restart_latency", n, 16);

        // single mismatch at vector 5 (expected {cout,sum}=01)
        do_clear();
        for (int i = 0; i < 8; i++) load(mkvec(i, i == 5));
        chk("vec5_encoding", mkvec(5, 1'b1), 5'b01101);
        run(n);
        chk("single_fail", fail_count, 1);
        chk("single_vld", first_fail_vld, 1'b1);
        chk("single_idx", first_fail_idx, 5);

        // full store, 17th load refused
        do_clear();
        for (int i = 0; i < 16; i++) load(mkvec(i & 7, (i % 5) == 2));
        chk("full_ready", load_ready, 1'b0);
        chk("full_count", vec_count, 16);
        load(mkvec(3, 1'b0));
        chk("full_17th", vec_count, 16);
        run(n);
        chk("full_latency", n, 32);
        chk("full_fail", fail_count, 3);
        chk("full_idx", first_fail_idx, 2);

        // reset during SETTLE of vector 3
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_cut", {cut_cin, cut_b, cut_a}, 3'd3);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_count", vec_count, 0);
        chk("rst_mid_ready", load_ready, 1'b1);
        chk("rst_mid_fail", fail_count, 0);
        chk("rst_mid_cut", {cut_cin, cut_b, cut_a}, 3'd0);
        rst = 1'b0;
        tick();

        // two-vector run for the signature
        load(mkvec(7, 1'b0));
        load(mkvec(0, 1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
`ifdef CUT_MISR_EN
        chk("misr_first", signature, 8'h03);
`endif
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk("misr_done", done, 1'b1);
        chk("misr_fail", fail_count, 0);
`ifdef CUT_MISR_EN
        chk("misr_final", signature, 8'h06);
`endif
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cut_vector_sequencer.md
# cut_vector_sequencer

Sequential test-vector applicator that drives the full-adder circuit-under-test (CUT) inputs `a`, `b`, `cin` and checks the CUT's `sum`/`cout` responses. It sits directly upstream and downstream of the adder netlist. PODEM-generated vectors, each carrying its expected response, are loaded through a valid/ready port. On `start`, every stored vector is applied in order, the CUT is allowed to settle, and the response is compared; the block reports the fail count and the first failing index.

## Interface
- `DEPTH`, 16: vector storage entries; power of two, ≥2.
- `SETTLE_CYC`, 1: cycles each vector is held before capture; ≥1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: load handshake valid.
- `load_ready` out 1: high when `state==IDLE` and `vec_count<DEPTH`.
- `load_vec` in 5: `{exp_cout, exp_sum, cin, b, a}`.
- `start` in 1: begin a run; sampled in IDLE/DONE.
- `clear` in 1: empty the vector store and results; sampled in IDLE/DONE.
- `busy` out 1: high in SETTLE/CAPTURE.
- `done` out 1: high in DONE.
- `cut_a`, `cut_b`, `cut_cin` out 1 each: registered CUT drive.
- `cut_sum`, `cut_cout` in 1 each: CUT response.
- `vec_count` out $clog2(DEPTH+1): number of stored vectors.
- `fail_count` out $clog2(DEPTH+1): number of mismatching vectors in the last run.
- `first_fail_vld` out 1: at least one mismatch occurred.
- `first_fail_idx` out $clog2(DEPTH): index of the first mismatch.

## Operation
- **Reset:** state IDLE; all outputs 0; `vec_count`=0; `load_ready`=1.
- **Load (IDLE only):** on `load_valid && load_ready`, write `load_vec` at index `vec_count`, then increment `vec_count`. At `vec_count==DEPTH`, `load_ready`=0 and further loads are not accepted.
- **Start priority in IDLE:**
  - A same-cycle load handshake wins; `start` is ignored and must be reasserted.
  - Otherwise `start` clears `fail_count`, `first_fail_*` and `idx`.
  - If `vec_count==0`, go directly to DONE.
  - Otherwise drive vector 0 onto `cut_*`, load the settle counter with `SETTLE_CYC`, and go to SETTLE.
- **SETTLE:** decrement the counter each cycle; after `SETTLE_CYC` cycles, go to CAPTURE.
- **CAPTURE (one cycle):**
  - Mismatch = `{cut_cout,cut_sum} != {exp_cout,exp_sum}` of vector `idx`.
  - On mismatch, increment `fail_count`. If `first_fail_vld`==0, also set it and latch `first_fail_idx=idx`.
  - If `idx==vec_count-1`, go to DONE; `cut_*` hold their last value.
  - Otherwise increment `idx`, drive the next vector, reload the counter, and go to SETTLE.
- **DONE:** results are held.
  - `start` restarts exactly as from IDLE, with the store retained.
  - `clear`: go to IDLE, `vec_count`=0, results zeroed. `clear` takes priority over `start`.
- `start`, `clear` and `load_valid` are ignored in SETTLE/CAPTURE.
- `rst` mid-run aborts immediately to the reset state; the store is discarded.

## Timing
- `cut_*` change only on the edge leaving IDLE/DONE (start) or leaving CAPTURE.
- Response sampling: at the edge ending CAPTURE, `SETTLE_CYC+1` cycles after the vector is driven.
- Per vector: `SETTLE_CYC+1` cycles.
- `done` rises at edge E0 + N·(`SETTLE_CYC`+1), where E0 is the start edge and N=`vec_count`.
- With N=0, `done` rises at E0.
- `busy` and `done` are never high together.
- `fail_count` and `first_fail_*` are stable while `done`=1.

## Configuration
- Macro: `CUT_MISR_EN`.
- **Defined:**
  - Adds output port `signature` [7:0], reset to 8'h00 and cleared by `start`/`clear`.
  - Each CAPTURE computes `sig = {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {6'b0, cut_cout, cut_sum}`.
- **Undefined:** no `signature` port and no MISR logic; all other behaviour is identical.

## Test plan
- **Exhaustive golden run:** load all 8 adder vectors with correct expected responses, `SETTLE_CYC`=1, golden CUT.
  - Required: `fail_count`=0, `first_fail_vld`=0, `done` exactly 16 cycles after the start edge.
- **Single mismatch:** same as above, but vector 5 (a=1,b=0,cin=1) is loaded with wrong expected `{cout,sum}`=2'b01.
  - Required: `fail_count`=1, `first_fail_idx`=5.
- **Full store:** load 16 vectors.
  - Required: `load_ready`=0, a 17th `load_valid` is not accepted, `vec_count`=16.
- **Empty run:** `start` with `vec_count`=0.
  - Required: `done`=1 on the next cycle, `fail_count`=0, `busy` never asserted.
- **Reset mid-run:** assert `rst` during SETTLE of vector 3.
  - Required: all outputs 0 the next cycle, `vec_count`=0, `load_ready`=1.
- **MISR (`CUT_MISR_EN`):** vectors (1,1,1) then (0,0,0), golden CUT.
  - Required: `signature`=8'h03 after the first capture and 8'h06 at `done`.
